alu_muldiv: RTL and testbench



---
 rtl/alu_pkg.sv | 28 ++
 rtl/muldiv_iter.sv | 120 ++++++++++++
 rtl/alu_muldiv.sv | 87 ++++++++
 tb/tb_alu_muldiv.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Opcode map, iterative-unit state type and decode helper shared by the ALU
// and its multiply/divide datapath.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_MULTU = 4'b1000;
    localparam logic [3:0] ALU_MULT  = 4'b1001;
    localparam logic [3:0] ALU_DIVU  = 4'b1010;
    localparam logic [3:0] ALU_DIV   = 4'b1011;
    localparam logic [3:0] ALU_MFHI  = 4'b1100;
    localparam logic [3:0] ALU_MFLO  = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } md_state_t;

    // 10xx: bit 1 selects divide, bit 0 selects signed
    function automatic logic is_muldiv(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider on operand
// magnitudes, with sign restoration and divide-by-zero handling in FIX.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             idle,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    md_state_t        state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd, a_raw;
    logic             div_q, neg_lo, neg_hi, div0;

    logic             neg_a, neg_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum, div_sh, div_diff;
    logic [2*WIDTH-1:0] prod;

    assign neg_a = is_signed & a[WIDTH-1];
    assign neg_b = is_signed & b[WIDTH-1];
    assign mag_a = neg_a ? -a : a;
    assign mag_b = neg_b ? -b : b;

    assign idle = (state == IDLE);
    assign done = (state == FIX);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ITER;
            ITER:    if (cnt == LAST) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_sh   = {acc_hi, acc_lo[WIDTH-1]};
        div_diff = div_sh - {1'b0, opnd};
    end

    // multiply: acc_lo starts as the multiplier and is shifted out as the
    // product's low half shifts in; divide: acc_lo holds dividend then quotient
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            a_raw  <= '0;
            div_q  <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            div0   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    cnt    <= '0;
                    acc_hi <= '0;
                    acc_lo <= is_div ? mag_a : mag_b;
                    opnd   <= is_div ? mag_b : mag_a;
                    a_raw  <= a;
                    div_q  <= is_div;
                    neg_lo <= neg_a ^ neg_b;
                    neg_hi <= neg_a;
                    div0   <= (b == '0);
                end
                ITER: begin
                    cnt <= cnt + 1'b1;
                    if (div_q) begin
                        acc_hi <= div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
                    end else begin
                        {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        prod = {acc_hi, acc_lo};
        if (neg_lo) prod = -prod;
        hi = prod[2*WIDTH-1:WIDTH];
        lo = prod[WIDTH-1:0];
        if (div_q) begin
            if (div0) begin
                lo = '1;
                hi = a_raw;
            end else begin
                lo = neg_lo ? -acc_lo : acc_lo;
                hi = neg_hi ? -acc_hi : acc_hi;
            end
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: single-cycle logic/arith ops plus an iterative
// multiply/divide unit feeding architectural HI/LO registers.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    input  logic [CTRL_W-1:0] ALUControl,
    output logic              out_valid,
    output logic [WIDTH-1:0]  Result,
    output logic              Zero,
    output logic              busy
);

    logic [3:0]       op;
    logic [WIDTH-1:0] hi_q, lo_q, md_hi, md_lo, simple_res;
    logic             accept, md_start, md_idle, md_done;

    // codes with any bit above the 4-bit opcode set fall into the ADD default
    always_comb begin
        op = ((ALUControl >> 4) == '0) ? ALUControl[3:0] : ALU_ADD;
        simple_res = '0;
        case (op)
            ALU_AND:  simple_res = A & B;
            ALU_OR:   simple_res = A | B;
            ALU_SUB:  simple_res = A - B;
            ALU_SLT:  simple_res[0] = ($signed(A) < $signed(B));
            ALU_MFHI: simple_res = hi_q;
            ALU_MFLO: simple_res = lo_q;
            default:  simple_res = A + B;
        endcase
    end

    assign in_ready = md_idle;
    assign busy     = ~md_idle;
    assign accept   = in_valid & in_ready;
    assign md_start = accept & is_muldiv(op);

    muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk       (clk),
        .reset     (reset),
        .start     (md_start),
        .is_div    (op[1]),
        .is_signed (op[0]),
        .a         (A),
        .b         (B),
        .idle      (md_idle),
        .done      (md_done),
        .hi        (md_hi),
        .lo        (md_lo)
    );

    // in_ready is low during FIX, so a completion never races a simple accept
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q      <= '0;
            lo_q      <= '0;
            Result    <= '0;
            Zero      <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (md_done) begin
                hi_q      <= md_hi;
                lo_q      <= md_lo;
                Result    <= md_lo;
                Zero      <= (md_lo == '0);
                out_valid <= 1'b1;
            end else if (accept && !is_muldiv(op)) begin
                Result    <= simple_res;
                Zero      <= (simple_res == '0);
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed vector table, hand-written
// multi-cycle sequences and random ops against a plain-arithmetic model.
module tb_alu_muldiv;

    localparam int W = 32;
    localparam logic [3:0] OP_AND = 4'h0, OP_OR = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h6,
                           OP_SLT = 4'h7, OP_MULTU = 4'h8, OP_MULT = 4'h9, OP_DIVU = 4'hA,
                           OP_DIV = 4'hB, OP_MFHI = 4'hC, OP_MFLO = 4'hD;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A, B;
    logic [3:0]   ALUControl;
    logic         out_valid;
    logic [W-1:0] Result;
    logic         Zero;
    logic         busy;

    alu_muldiv #(.WIDTH(W), .CTRL_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .ALUControl (ALUControl),
        .out_valid  (out_valid),
        .Result     (Result),
        .Zero       (Zero),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // reference: architectural result and HI/LO update from plain arithmetic
    task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] res);
        logic [63:0] p;
        longint      sa64, sb64;
        int          sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_SUB: res = a - b;
            OP_SLT: res = (sa < sb) ? 32'd1 : 32'd0;
            OP_MFHI: res = m_hi;
            OP_MFLO: res = m_lo;
            OP_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                m_hi = p[63:32]; m_lo = p[31:0]; res = m_lo;
            end
            OP_MULT: begin
                sa64 = sa; sb64 = sb;
                p = sa64 * sb64;
                m_hi = p[63:32]; m_lo = p[31:0]; res = m_lo;
            end
            OP_DIVU, OP_DIV: begin
                if (b == 0) begin
                    m_lo = '1; m_hi = a;
                end else if (op == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000; m_hi = 0;
                end else if (op == OP_DIV) begin
                    m_lo = sa / sb; m_hi = sa % sb;
                end else begin
                    m_lo = a / b; m_hi = a % b;
                end
                res = m_lo;
            end
            default: res = a + b;
        endcase
    endtask

    // latency: 1 = out_valid seen right after the accept edge
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] res, output logic z, output int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("ready_timeout", 1, 0);
        in_valid = 1'b1; ALUControl = op; A = a; B = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = Result;
        z = Zero;
    endtask

    function automatic int exp_lat(input logic [3:0] op);
        return (op[3:2] == 2'b10) ? W + 2 : 1;
    endfunction

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a, b, res, hi, lo;
        bit           hl;
    } vec_t;

    vec_t vt[13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] res, exp;
        logic         z;
        int           lat;
        int           busy_n, pulses, first_e, second_e, acc_e, seen;
        logic [W-1:0] r1, r2;
        bit           dropped;
        logic [3:0]   ops[13];

        vt[0]  = '{OP_ADD,   32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 0, 0, 1'b0};
        vt[1]  = '{OP_SUB,   32'd5,         32'd5,         32'h0,         0, 0, 1'b0};
        vt[2]  = '{OP_SLT,   32'hFFFF_FFFF, 32'd1,         32'd1,         0, 0, 1'b0};
        vt[3]  = '{OP_SLT,   32'd1,         32'hFFFF_FFFF, 32'd0,         0, 0, 1'b0};
        vt[4]  = '{OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1};
        vt[5]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFE, 32'h1, 1'b1};
        vt[6]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1};
        vt[7]  = '{OP_DIVU,  32'd100,       32'd0,         32'hFFFF_FFFF, 32'd100, 32'hFFFF_FFFF, 1'b1};
        vt[8]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 32'h8000_0000, 1'b1};
        vt[9]  = '{OP_DIV,   32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1};
        vt[10] = '{4'hF,     32'd4,         32'd9,         32'd13,        0, 0, 1'b0};
        vt[11] = '{OP_AND,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0, 1'b0};
        vt[12] = '{OP_OR,    32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 0, 0, 1'b0};

        reset = 1'b1; in_valid = 1'b0; A = '0; B = '0; ALUControl = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", Result, 0);
        check("rst_zero", Zero, 1);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            model(vt[i].op, vt[i].a, vt[i].b, exp);
            issue(vt[i].op, vt[i].a, vt[i].b, res, z, lat);
            check($sformatf("vec%0d_result", i), res, vt[i].res);
            check($sformatf("vec%0d_zero", i), z, vt[i].res == 0);
            check($sformatf("vec%0d_latency", i), lat, exp_lat(vt[i].op));
            if (vt[i].hl) begin
                model(OP_MFHI, 0, 0, exp);
                issue(OP_MFHI, 0, 0, res, z, lat);
                check($sformatf("vec%0d_mfhi", i), res, vt[i].hi);
                model(OP_MFLO, 0, 0, exp);
                issue(OP_MFLO, 0, 0, res, z, lat);
                check($sformatf("vec%0d_mflo", i), res, vt[i].lo);
            end
        end

        // ADD held on in_valid while a DIV iterates
        model(OP_DIV, 32'd100, 32'd7, exp);
        @(negedge clk);
        in_valid = 1'b1; ALUControl = OP_DIV; A = 32'd100; B = 32'd7;
        @(posedge clk); #1;
        ALUControl = OP_ADD; A = 32'd2; B = 32'd3;
        busy_n = 0; pulses = 0; first_e = -1; second_e = -1; acc_e = -1;
        r1 = '0; r2 = '0; dropped = 1'b0;
        for (int e = 1; e <= 45; e++) begin
            @(negedge clk);
            if (!in_ready) begin
                busy_n++;
            end else if (!dropped) begin
                dropped = 1'b1;
                acc_e = e;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (out_valid) begin
                pulses++;
                if (pulses == 1) begin first_e = e; r1 = Result; end
                else begin second_e = e; r2 = Result; end
            end
        end
        in_valid = 1'b0;
        check("hold_busy_cycles", busy_n, W + 1);
        check("hold_pulses", pulses, 2);
        check("hold_div_edge", first_e, W + 1);
        check("hold_div_result", r1, 32'd14);
        check("hold_add_accept", acc_e, W + 2);
        check("hold_add_edge", second_e, W + 2);
        check("hold_add_result", r2, 32'd5);

        // reset in the middle of a MULT
        @(negedge clk);
        in_valid = 1'b1; ALUControl = OP_MULT; A = 32'hFFFF_FFFD; B = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_out_valid", out_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("midrst_no_pulse", seen, 0);
        issue(OP_MFHI, 0, 0, res, z, lat);
        check("midrst_mfhi", res, 0);
        issue(OP_MFLO, 0, 0, res, z, lat);
        check("midrst_mflo", res, 0);
        issue(OP_ADD, 32'd2, 32'd3, res, z, lat);
        check("midrst_add", res, 32'd5);

        // back-to-back ANDs
        @(negedge clk);
        in_valid = 1'b1; ALUControl = OP_AND; A = 32'hF0F0_F0F0; B = 32'hFF00_FF00;
        @(posedge clk); #1;
        check("b2b_valid1", out_valid, 1);
        check("b2b_result1", Result, 32'hF000_F000);
        @(negedge clk);
        A = 32'h0F0F_0F0F; B = 32'hF0F0_F0F0;
        @(posedge clk); #1;
        check("b2b_valid2", out_valid, 1);
        check("b2b_result2", Result, 32'h0);
        check("b2b_zero2", Zero, 1);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b_valid3", out_valid, 0);

        ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_MULTU, OP_MULT,
                OP_DIVU, OP_DIV, OP_MFHI, OP_MFLO, 4'hF, 4'h3};
        for (int i = 0; i < 60; i++) begin
            logic [3:0]   op;
            logic [W-1:0] a, b;
            op = ops[$urandom_range(0, 12)];
            case ($urandom_range(0, 5))
                0: a = 32'h0;
                1: a = 32'h8000_0000;
                2: a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0: b = 32'h0;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(1, 20);
                3: b = 32'h8000_0000;
                default: b = $urandom;
            endcase
            model(op, a, b, exp);
            issue(op, a, b, res, z, lat);
            check($sformatf("rnd%0d_op%0h_result", i, op), res, exp);
            check($sformatf("rnd%0d_zero", i), z, exp == 0);
            check($sformatf("rnd%0d_latency", i), lat, exp_lat(op));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
